// File: rtl/word_packer_pkg.sv
// word_packer_pkg: shared sizes and state encoding for the word packer
package word_packer_pkg;
  localparam int WORD_W = 10;
  localparam int N_WORDS = 48;
  localparam int FRAME_W = WORD_W * N_WORDS;
  localparam int CNT_W = 6;
  typedef enum logic {FILL, HOLD} state_e;
endpackage

// File: rtl/word_packer.sv
// word_packer: packs WORD_W-bit words into N_WORDS-word frames with flush and a one-frame output slot
module word_packer
  import word_packer_pkg::*;
#(
  parameter int WORD_W = word_packer_pkg::WORD_W,
  parameter int N_WORDS = word_packer_pkg::N_WORDS,
  parameter int FRAME_W = WORD_W * N_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [FRAME_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count
);
  state_e state_q, state_d;
  logic [FRAME_W-1:0] acc_q, acc_d, acc_w, out_data_q, out_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_w, out_count_q, out_count_d;
  logic out_valid_q, out_valid_d, alive_q, accept, slot_free, close;
  assign in_ready = alive_q && state_q == FILL;
  assign out_data = out_data_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  always_comb begin
    accept = in_valid && in_ready;
    slot_free = !out_valid_q || out_ready;
    acc_w = acc_q;
    for (int k = 0; k < N_WORDS; k++)
      if (accept && cnt_q == CNT_W'(k)) acc_w[k*WORD_W +: WORD_W] = in_data;
    cnt_w = cnt_q + CNT_W'(accept);
    // HOLD always carries a closed frame; in FILL a word landing in the last slot wins over flush
    close = state_q == HOLD || cnt_w == CNT_W'(N_WORDS) || (flush && |cnt_w);
    out_valid_d = out_valid_q && !out_ready;
    out_data_d = out_data_q;
    out_count_d = out_count_q;
    acc_d = acc_w;
    cnt_d = cnt_w;
    state_d = close ? HOLD : FILL;
    if (close && slot_free) begin
      out_data_d = acc_w;
      out_count_d = cnt_w;
      out_valid_d = 1'b1;
      acc_d = '0;
      cnt_d = '0;
      state_d = FILL;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      acc_q <= '0;
      cnt_q <= '0;
      out_data_q <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_data_q <= out_data_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      alive_q <= 1'b1;
    end
  end
endmodule
